bus_fabric: RTL and testbench

BUS_FABRIC -- requirements
Module: bus_fabric

---
 rtl/bus_fabric.sv | 173 +++++++++++++++++
 tb/tb_bus_fabric.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_fabric.sv
// Single-master fabric to N_SLV slaves: address decode, one outstanding request, sticky first-fault capture.
// Defining BUS_FABRIC_TIMEOUT_EN adds a TMO_CYCLES response timeout; without it WAIT may last forever.
module bus_fabric #(
    parameter int                  N_SLV      = 9,
    parameter logic [N_SLV*32-1:0] SLV_BASE   = '0,
    parameter logic [N_SLV*32-1:0] SLV_MASK   = '0,
    parameter int                  TMO_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [31:0]           m_addr,
    input  logic                  m_w_rb,
    input  logic [1:0]            m_acc,
    input  logic [31:0]           m_wdata,
    input  logic                  m_req,
    output logic [31:0]           m_rdata,
    output logic                  m_resp,
    output logic                  m_fault,
    output logic [2:0]            fault_cause,
    output logic [3:0]            fault_idx,
    output logic [31:0]           s_addr,
    output logic                  s_w_rb,
    output logic [1:0]            s_acc,
    output logic [31:0]           s_wdata,
    output logic [N_SLV-1:0]      s_req,
    input  logic [N_SLV-1:0]      s_resp,
    input  logic [N_SLV-1:0]      s_fault,
    input  logic [N_SLV*32-1:0]   s_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FAULT} state_t;
    typedef enum logic [2:0] {
        C_NONE  = 3'd0,
        C_MISS  = 3'd1,
        C_SLAVE = 3'd2,
        C_TMO   = 3'd3,
        C_PROTO = 3'd4
    } cause_t;

    state_t      state;
    cause_t      cause_q;
    cause_t      det_cause;
    logic [3:0]  sel;
    logic [3:0]  idx_q;
    logic [3:0]  det_idx;
    logic [3:0]  hit_idx;
    logic        hit;
    logic [15:0] resp_pad;
    logic [15:0] fault_pad;
    logic [15:0] req_pad;
    logic [31:0] rdata_sel;
    logic        in_idle;
    logic        in_wait;
    logic        resp_sel;
    logic        issue;
    logic        tmo_hit;

    assign s_addr      = m_addr;
    assign s_w_rb      = m_w_rb;
    assign s_acc       = m_acc;
    assign s_wdata     = m_wdata;
    assign fault_cause = cause_q;
    assign fault_idx   = idx_q;

    assign in_idle  = (state == S_IDLE);
    assign in_wait  = (state == S_WAIT);
    assign resp_sel = in_wait && resp_pad[sel];
    // A request is decoded in IDLE, or in the WAIT cycle whose response frees the port.
    assign issue    = m_req && (in_idle || resp_sel);

    // Slave vectors are widened to 16 so a 4-bit index selects them for any N_SLV.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        resp_pad  = '0;
        fault_pad = '0;
        rdata_sel = '0;
        hit       = 1'b0;
        hit_idx   = '0;
        resp_pad[N_SLV-1:0]  = s_resp;
        fault_pad[N_SLV-1:0] = s_fault;
        for (int i = 0; i < N_SLV; i++) begin
            if (4'(i) == sel) rdata_sel = s_rdata[32*i +: 32];
        end
        // Descending scan so the lowest matching index is the one left standing.
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((m_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                hit     = 1'b1;
                hit_idx = 4'(i);
            end
        end
    end

`ifdef BUS_FABRIC_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic [16:0] tmo_next;

    assign tmo_next = {1'b0, tmo_cnt} + 17'd1;
    assign tmo_hit  = in_wait && !resp_sel && (tmo_next == 17'(TMO_CYCLES));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_cnt <= '0;
        end else if (issue && hit) begin
            tmo_cnt <= '0;
        end else if (in_wait && !resp_sel) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Same-cycle priority: protocol > miss > slave fault > timeout.
    always_comb begin
        det_cause = C_NONE;
        det_idx   = '0;
        if (in_wait && m_req && !resp_sel) begin
            det_cause = C_PROTO;
            det_idx   = sel;
        end else if (issue && !hit) begin
            det_cause = C_MISS;
            det_idx   = '0;
        end else if (in_wait && fault_pad[sel]) begin
            det_cause = C_SLAVE;
            det_idx   = sel;
        end else if (issue && fault_pad[hit_idx]) begin
            det_cause = C_SLAVE;
            det_idx   = hit_idx;
        end else if (tmo_hit) begin
            det_cause = C_TMO;
            det_idx   = sel;
        end
    end

    always_comb begin
        req_pad = '0;
        if (issue && hit) req_pad[hit_idx] = 1'b1;
    end

    assign s_req   = req_pad[N_SLV-1:0];
    assign m_resp  = resp_sel && (det_cause == C_NONE);
    assign m_rdata = rdata_sel;

    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rstn) begin
            state   <= S_IDLE;
            sel     <= '0;
            cause_q <= C_NONE;
            idx_q   <= '0;
            m_fault <= 1'b0;
            busy    <= 1'b0;
        end else if (state != S_FAULT) begin
            // FAULT is only left through reset, so the first recorded cause is never overwritten.
            if (det_cause != C_NONE) begin
                state   <= S_FAULT;
                cause_q <= det_cause;
                idx_q   <= det_idx;
                m_fault <= 1'b1;
                busy    <= 1'b0;
            end else if (issue && hit) begin
                state <= S_WAIT;
                sel   <= hit_idx;
                busy  <= 1'b1;
            end else if (resp_sel) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bus_fabric.sv
// Self-checking bench for bus_fabric: directed scenarios plus randomized episodes against a transaction-level model.
module tb_bus_fabric;

    localparam int N   = 3;
    localparam int TMO = 4;
    localparam logic [N*32-1:0] BASES = {32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
    localparam logic [N*32-1:0] MASKS = {3{32'hFFFF_F000}};
`ifdef BUS_FABRIC_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [31:0]     m_addr = '0;
    logic            m_w_rb = 1'b0;
    logic [1:0]      m_acc = '0;
    logic [31:0]     m_wdata = '0;
    logic            m_req = 1'b0;
    logic [31:0]     m_rdata;
    logic            m_resp;
    logic            m_fault;
    logic [2:0]      fault_cause;
    logic [3:0]      fault_idx;
    logic [31:0]     s_addr;
    logic            s_w_rb;
    logic [1:0]      s_acc;
    logic [31:0]     s_wdata;
    logic [N-1:0]    s_req;
    logic [N-1:0]    s_resp = '0;
    logic [N-1:0]    s_fault = '0;
    logic [N*32-1:0] s_rdata = '0;
    logic            busy;

    int n_checks = 0;
    int n_err    = 0;

    // Transaction-level model: is a request outstanding, to whom, for how long, and has the fabric died.
    bit mdl_busy;
    int mdl_tgt;
    int mdl_age;
    bit mdl_dead;
    int mdl_cause;
    int mdl_idx;

    logic [N-1:0] last_sreq;
    logic         last_resp;
    logic [31:0]  last_rdata;
    logic         last_busy;
    logic         last_fault;
    logic [2:0]   last_cause;
    logic [3:0]   last_idx;

    bus_fabric #(
        .N_SLV      (N),
        .SLV_BASE   (BASES),
        .SLV_MASK   (MASKS),
        .TMO_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .m_addr      (m_addr),
        .m_w_rb      (m_w_rb),
        .m_acc       (m_acc),
        .m_wdata     (m_wdata),
        .m_req       (m_req),
        .m_rdata     (m_rdata),
        .m_resp      (m_resp),
        .m_fault     (m_fault),
        .fault_cause (fault_cause),
        .fault_idx   (fault_idx),
        .s_addr      (s_addr),
        .s_w_rb      (s_w_rb),
        .s_acc       (s_acc),
        .s_wdata     (s_wdata),
        .s_req       (s_req),
        .s_resp      (s_resp),
        .s_fault     (s_fault),
        .s_rdata     (s_rdata),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // Slave i owns the 4 KiB page numbered i; anything else is unmapped.
    function automatic int target_of(input logic [31:0] a);
        if (a[31:12] < 20'd3) return int'(a[31:12]);
        return -1;
    endfunction

    task automatic mdl_clear();
        mdl_busy  = 1'b0;
        mdl_tgt   = 0;
        mdl_age   = 0;
        mdl_dead  = 1'b0;
        mdl_cause = 0;
        mdl_idx   = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn    = 1'b0;
        m_req   = 1'b0;
        s_resp  = '0;
        s_fault = '0;
        #1;
        check("rst_busy",  64'(busy), 64'(0));
        check("rst_fault", 64'(m_fault), 64'(0));
        check("rst_cause", 64'(fault_cause), 64'(0));
        check("rst_idx",   64'(fault_idx), 64'(0));
        check("rst_sreq",  64'(s_req), 64'(0));
        check("rst_resp",  64'(m_resp), 64'(0));
        mdl_clear();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // One bus cycle: drive at the falling edge, compare against the model, then advance the model.
    task automatic cycle(input bit req, input logic [31:0] addr, input logic [N-1:0] resp,
                         input logic [N-1:0] flt, input logic [N*32-1:0] rd);
        int           t;
        int           cause;
        int           idx;
        bit           done;
        bit           take;
        logic [N-1:0] e_sreq;
        bit           e_resp;
        logic [31:0]  wd;
        logic [2:0]   ctl;
        @(negedge clk);
        wd      = $urandom;
        ctl     = 3'($urandom);
        m_req   = req;
        m_addr  = addr;
        m_wdata = wd;
        m_w_rb  = ctl[2];
        m_acc   = ctl[1:0];
        s_resp  = resp;
        s_fault = flt;
        s_rdata = rd;
        #2;
        t     = target_of(addr);
        done  = mdl_busy && resp[mdl_tgt];
        take  = !mdl_dead && (!mdl_busy || done) && req;
        cause = 0;
        idx   = 0;
        if (!mdl_dead) begin
            if (mdl_busy && req && !done) begin
                cause = 4; idx = mdl_tgt;
            end else if (take && t < 0) begin
                cause = 1; idx = 0;
            end else if (mdl_busy && flt[mdl_tgt]) begin
                cause = 2; idx = mdl_tgt;
            end else if (take && flt[t]) begin
                cause = 2; idx = t;
            end else if (TMO_ON && mdl_busy && !done && mdl_age + 1 == TMO) begin
                cause = 3; idx = mdl_tgt;
            end
        end
        e_sreq = '0;
        if (take && t >= 0) e_sreq[t] = 1'b1;
        e_resp = done && (cause == 0);

        last_sreq  = s_req;
        last_resp  = m_resp;
        last_rdata = m_rdata;
        last_busy  = busy;
        last_fault = m_fault;
        last_cause = fault_cause;
        last_idx   = fault_idx;

        check("s_req",       64'(s_req), 64'(e_sreq));
        check("m_resp",      64'(m_resp), 64'(e_resp));
        if (e_resp) check("m_rdata", 64'(m_rdata), 64'(rd[32*mdl_tgt +: 32]));
        check("busy",        64'(busy), 64'(mdl_busy));
        check("m_fault",     64'(m_fault), 64'(mdl_dead));
        check("fault_cause", 64'(fault_cause), 64'(mdl_cause));
        check("fault_idx",   64'(fault_idx), 64'(mdl_idx));
        check("s_addr",      64'(s_addr), 64'(addr));
        check("s_ctl_wdata", {29'b0, s_w_rb, s_acc, s_wdata}, {29'b0, ctl, wd});

        if (cause != 0) begin
            mdl_dead  = 1'b1;
            mdl_busy  = 1'b0;
            mdl_cause = cause;
            mdl_idx   = idx;
        end else if (take) begin
            mdl_busy = 1'b1;
            mdl_tgt  = t;
            mdl_age  = 0;
        end else if (done) begin
            mdl_busy = 1'b0;
        end else if (mdl_busy) begin
            mdl_age++;
        end
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 32'h0, '0, '0, {N{32'h0}});
    endtask

    initial begin
        mdl_clear();
        do_reset();

        // Read from slave 1 answered two cycles after the request.
        cycle(1'b1, 32'h0000_1004, '0, '0, '0);
        check("t1_sreq", 64'(last_sreq), 64'(3'b010));
        idle_cycle();
        check("t1_busy", 64'(last_busy), 64'(1));
        check("t1_sreq_off", 64'(last_sreq), 64'(0));
        cycle(1'b0, 32'h0, 3'b010, '0, {32'h0, 32'hDEAD_BEEF, 32'h0});
        check("t1_resp", 64'(last_resp), 64'(1));
        check("t1_rdata", 64'(last_rdata), 64'(32'hDEAD_BEEF));
        idle_cycle();
        check("t1_idle", 64'(last_busy), 64'(0));

        // Unmapped address: no slave request, fault is sticky.
        do_reset();
        cycle(1'b1, 32'h0000_8000, '0, '0, '0);
        check("t2_sreq", 64'(last_sreq), 64'(0));
        cycle(1'b1, 32'h0000_1000, 3'b111, '0, '0);
        check("t2_fault", 64'(last_fault), 64'(1));
        check("t2_cause", 64'(last_cause), 64'(1));
        check("t2_resp", 64'(last_resp), 64'(0));
        check("t2_sreq_dead", 64'(last_sreq), 64'(0));

        // Back-to-back: slave 0 completes while the next request goes to slave 2.
        do_reset();
        cycle(1'b1, 32'h0000_0010, '0, '0, '0);
        cycle(1'b1, 32'h0000_2000, 3'b001, '0, {32'h0, 32'h0, 32'h1234_5678});
        check("t3_sreq", 64'(last_sreq), 64'(3'b100));
        check("t3_resp", 64'(last_resp), 64'(1));
        idle_cycle();
        check("t3_busy", 64'(last_busy), 64'(1));
        check("t3_nofault", 64'(last_fault), 64'(0));
        cycle(1'b0, 32'h0, 3'b100, '0, '0);

        // Second request while the first is outstanding.
        do_reset();
        cycle(1'b1, 32'h0000_1000, '0, '0, '0);
        cycle(1'b1, 32'h0000_2000, '0, '0, '0);
        check("t4_sreq", 64'(last_sreq), 64'(0));
        idle_cycle();
        check("t4_cause", 64'(last_cause), 64'(4));
        check("t4_idx", 64'(last_idx), 64'(1));
        cycle(1'b0, 32'h0, '0, 3'b111, '0);
        idle_cycle();
        check("t4_cause_held", 64'(last_cause), 64'(4));

        // Silent slave: timeout after TMO wait cycles when enabled, otherwise waits on.
        do_reset();
        cycle(1'b1, 32'h0000_2000, '0, '0, '0);
        for (int i = 0; i < TMO; i++) idle_cycle();
        idle_cycle();
        if (TMO_ON) begin
            check("t5_cause", 64'(last_cause), 64'(3));
            check("t5_idx", 64'(last_idx), 64'(2));
        end else begin
            check("t5_busy", 64'(last_busy), 64'(1));
            check("t5_nofault", 64'(last_fault), 64'(0));
        end
        do_reset();
        cycle(1'b1, 32'h0000_1000, '0, '0, '0);
        for (int i = 0; i < TMO - 1; i++) idle_cycle();
        cycle(1'b0, 32'h0, 3'b010, '0, {32'h0, 32'hCAFE_F00D, 32'h0});
        check("t5_late_resp", 64'(last_resp), 64'(1));
        idle_cycle();
        check("t5_late_ok", 64'(last_fault), 64'(0));
        check("t5_late_idle", 64'(last_busy), 64'(0));

        // Reset mid-transaction; the orphaned response afterwards is ignored.
        do_reset();
        cycle(1'b1, 32'h0000_1000, '0, '0, '0);
        idle_cycle();
        do_reset();
        cycle(1'b0, 32'h0, 3'b010, '0, '0);
        check("t6_resp", 64'(last_resp), 64'(0));
        check("t6_busy", 64'(last_busy), 64'(0));

        // Randomized episodes; each ends a few cycles after the fabric faults.
        for (int e = 0; e < 80; e++) begin
            int dead_cycles;
            do_reset();
            dead_cycles = 0;
            for (int c = 0; c < 40 && dead_cycles < 3; c++) begin
                bit              req;
                logic [31:0]     a;
                logic [N-1:0]    r;
                logic [N-1:0]    f;
                logic [N*32-1:0] rd;
                req = mdl_busy ? ($urandom_range(0, 99) < 12) : ($urandom_range(0, 99) < 55);
                case ($urandom_range(0, 9))
                    0:       a = 32'h0000_8000 | 32'($urandom_range(0, 4095));
                    1:       a = $urandom;
                    default: a = {20'($urandom_range(0, 2)), 12'($urandom)};
                endcase
                for (int i = 0; i < N; i++) begin
                    r[i] = ($urandom_range(0, 9) < 4);
                    f[i] = ($urandom_range(0, 39) == 0);
                end
                rd = {$urandom, $urandom, $urandom};
                cycle(req, a, r, f, rd);
                if (mdl_dead) dead_cycles++;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
